// File: rtl/alu_sequencer.sv
// Issue-side controller: regfile operand fetch, alu EN/OE sequencing, writeback and flag word.
// Latency: accept-to-WB_VALID 3 cycles, 1 instruction per 4 cycles (unsupported opcode: 1 cycle).
// Backpressure: INSTR_READY high only in IDLE; INSTR_VALID is ignored in every other state.
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             INSTR_VALID,
    output logic             INSTR_READY,
    input  logic [3:0]       OPCODE_IN,
    input  logic [AW-1:0]    DST,
    input  logic [AW-1:0]    SRCA,
    input  logic [AW-1:0]    SRCB,
    input  logic             LD_EN,
    input  logic [AW-1:0]    LD_ADDR,
    input  logic [WIDTH-1:0] LD_DATA,
    input  logic [AW-1:0]    RD_ADDR,
    output logic [WIDTH-1:0] RD_DATA,
    output logic [3:0]       ALU_OPCODE,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic             ALU_EN,
    output logic             ALU_OE,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             ALU_CF,
    output logic             WB_VALID,
    output logic [AW-1:0]    WB_ADDR,
    output logic [WIDTH-1:0] WB_DATA,
    output logic             ERR,
    output logic [3:0]       FLAGS
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_NOTA = 4'b0111;

    logic [1:0]       state;
    logic             err_q;
    logic [WIDTH-1:0] regfile [NREGS];
    logic             op_ok;
    logic             accept;
    logic             is_add;
    logic             is_sub;
    logic             cf_n;
    logic             of_n;
    logic             msb_a;
    logic             msb_b;
    logic             msb_r;

    assign INSTR_READY = (state == S_IDLE);
    assign accept      = INSTR_VALID && INSTR_READY;
    assign op_ok       = (OPCODE_IN >= OP_ADD) && (OPCODE_IN <= OP_NOTA);
    assign ALU_EN      = (state == S_ISSUE);
    assign ALU_OE      = (state == S_WAIT);
    assign WB_VALID    = (state == S_DONE);
    assign ERR         = (state == S_DONE) && err_q;
    assign RD_DATA     = regfile[RD_ADDR];

    assign msb_a = ALU_A[WIDTH-1];
    assign msb_b = ALU_B[WIDTH-1];
    assign msb_r = ALU_OUT[WIDTH-1];

    // Carry comes from the alu; signed overflow is derived here from operand/result signs.
    always_comb begin
        is_add = (ALU_OPCODE == OP_ADD);
        is_sub = (ALU_OPCODE == OP_SUB);
        cf_n   = 1'b0;
        of_n   = 1'b0;
        if (is_add) begin
            cf_n = ALU_CF;
            of_n = (msb_a == msb_b) && (msb_r != msb_a);
        end else if (is_sub) begin
            cf_n = ALU_CF;
            of_n = (msb_a != msb_b) && (msb_r != msb_a);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            err_q      <= 1'b0;
            ALU_OPCODE <= '0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            WB_ADDR    <= '0;
            WB_DATA    <= '0;
            FLAGS      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ALU_OPCODE <= OPCODE_IN;
                        WB_ADDR    <= DST;
                        ALU_A      <= regfile[SRCA];
                        ALU_B      <= regfile[SRCB];
                        err_q      <= !op_ok;
                        if (op_ok) begin
                            state <= S_ISSUE;
                        end else begin
                            WB_DATA <= '0;
                            state   <= S_DONE;
                        end
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    WB_DATA <= ALU_OUT;
                    FLAGS   <= {cf_n, of_n, msb_r, (ALU_OUT == '0)};
                    state   <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Host load first so a same-cycle writeback to the same index overrides it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) regfile[i] <= '0;
        end else begin
            if (LD_EN) regfile[LD_ADDR] <= LD_DATA;
            if (state == S_WAIT) regfile[WB_ADDR] <= ALU_OUT;
        end
    end

endmodule
